// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the decode-stage register file and its scoreboard.
package regfile_sb_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int REG_ZERO   = 0;

  typedef struct packed {
    logic haz1;
    logic haz2;
    logic waw;
  } hazard_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy tracking: issue reserves a destination, writeback releases it.
module reg_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic              iss_we,
  input  logic [ADDR_W-1:0] iss_wa,
  output hazard_t           haz
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             fwd1;
  logic             fwd2;

  // Set is applied after clear so a new producer wins over the retiring one.
  always_comb begin
    busy_nxt = busy;
    if (we3)
      busy_nxt[wa3] = 1'b0;
    if (iss_we && (iss_wa != ZERO))
      busy_nxt[iss_wa] = 1'b1;
    busy_nxt[ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  assign fwd1 = (BYPASS != 0) && we3 && (wa3 == ra1);
  assign fwd2 = (BYPASS != 0) && we3 && (wa3 == ra2);

  assign haz.haz1 = busy[ra1] && !fwd1;
  assign haz.haz2 = busy[ra2] && !fwd2;
  assign haz.waw  = iss_we && (iss_wa != ZERO) && busy[iss_wa] &&
                    !(we3 && (wa3 == iss_wa));

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write-to-read bypass, optional registered
// read, and an integrated RAW/WAW scoreboard for the decode stage.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BYPASS    = 1,
  parameter int SYNC_READ = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [WIDTH-1:0]  wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic              iss_we,
  input  logic [ADDR_W-1:0] iss_wa,
  output logic              haz1,
  output logic              haz2,
  output logic              waw
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] rd1_c;
  logic [WIDTH-1:0] rd2_c;
  hazard_t          hz;

  // Entry 0 is cleared by reset and never written, so it always reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (we3 && (wa3 != ZERO)) begin
      regs[wa3] <= wd3;
    end
  end

  assign rd1_c = ((BYPASS != 0) && we3 && (wa3 == ra1) && (ra1 != ZERO)) ? wd3 : regs[ra1];
  assign rd2_c = ((BYPASS != 0) && we3 && (wa3 == ra2) && (ra2 != ZERO)) ? wd3 : regs[ra2];

  generate
    if (SYNC_READ != 0) begin : g_sync_read
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd1 <= '0;
          rd2 <= '0;
        end else begin
          rd1 <= rd1_c;
          rd2 <= rd2_c;
        end
      end
    end else begin : g_comb_read
      assign rd1 = rd1_c;
      assign rd2 = rd2_c;
    end
  endgenerate

  reg_scoreboard #(
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk    (clk),
    .reset  (reset),
    .we3    (we3),
    .wa3    (wa3),
    .ra1    (ra1),
    .ra2    (ra2),
    .iss_we (iss_we),
    .iss_wa (iss_wa),
    .haz    (hz)
  );

  assign haz1 = hz.haz1;
  assign haz2 = hz.haz2;
  assign waw  = hz.waw;

endmodule
